tdm_demux_4ch: RTL

Receive-side counterpart of the team's 4:1 multiplexer. It takes a time-division-multiplexed word stream (slot order a, b, c, d) with a frame-sync marker on slot a. It distributes each word to one of four registered channel outputs and flags framing errors. It sits downstream of a TDM link built from the mux, so the four original sources are recovered on the far side.

---
 rtl/tdm_demux_4ch_pkg.sv | 29 ++
 rtl/tdm_slot_ctr.sv | 48 ++++
 rtl/tdm_demux_4ch.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/tdm_demux_4ch_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux_4ch_pkg
// Shared slot and state encodings for the 4-slot TDM link. A future TDM
// transmitter imports the same package so both ends agree on slot order and
// state values.
//   SLOT_A..SLOT_D : 2-bit slot numbers in wire order a, b, c, d
//   state_e        : receiver framing state (HUNT / LOCKED)
//   slot_onehot()  : slot number -> 4-bit channel write-enable
// -----------------------------------------------------------------------------
package tdm_demux_4ch_pkg;

    localparam int NUM_SLOTS = 4;

    localparam logic [1:0] SLOT_A = 2'b00;
    localparam logic [1:0] SLOT_B = 2'b01;
    localparam logic [1:0] SLOT_C = 2'b10;
    localparam logic [1:0] SLOT_D = 2'b11;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Channel write-enable for a slot: bit n enables channel n (a=0 .. d=3).
    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [1:0] slot);
        return 4'b0001 << slot;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// -----------------------------------------------------------------------------
// tdm_slot_ctr
// 2-bit slot counter tracking which TDM slot the next valid word belongs to.
// Priority: load (sync, go to slot b) > clear (go to slot a) > increment.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : synchronous active-low reset, counter -> SLOT_A
//   load_i  : a slot-a word was just accepted; next expected slot is b
//   clr_i   : force back to slot a (loss of lock)
//   inc_i   : advance one slot, wrapping d -> a
//   slot_o  : current expected slot {s1,s0}
// -----------------------------------------------------------------------------
module tdm_slot_ctr
    import tdm_demux_4ch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [1:0] slot_o
);

    logic [1:0] slot_q;
    logic [1:0] slot_d;

    always_comb begin
        slot_d = slot_q;
        if (load_i) begin
            slot_d = SLOT_B;
        end else if (clr_i) begin
            slot_d = SLOT_A;
        end else if (inc_i) begin
            slot_d = slot_q + 2'd1;   // natural 2-bit wrap d -> a
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= SLOT_A;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux_4ch.sv
// -----------------------------------------------------------------------------
// tdm_demux_4ch
// Receive side of the 4:1 TDM link. Words arrive in slot order a, b, c, d with
// frame_sync marking slot a. Each accepted word is registered onto its channel
// output one clock after the din_valid cycle, with a matching one-cycle strobe.
// Framing errors (early sync, missing sync) pulse sync_err.
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset
//   din, din_valid           : TDM word and its qualifier (gaps allowed)
//   frame_sync               : din is slot a (only meaningful with din_valid)
//   a, b, c, d               : registered channel data, held until rewritten
//   a_vld .. d_vld           : one-cycle update strobes
//   s1, s0                   : slot expected for the next valid word
//   locked                   : receiver is in the LOCKED state
//   frame_done               : complete a..d frame received (with d_vld)
//   sync_err                 : one-cycle framing violation pulse
// -----------------------------------------------------------------------------
module tdm_demux_4ch
    import tdm_demux_4ch_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             a_vld,
    output logic             b_vld,
    output logic             c_vld,
    output logic             d_vld,
    output logic             s1,
    output logic             s0,
    output logic             locked,
    output logic             frame_done,
    output logic             sync_err
);

    state_e                 state_q, state_d;
    logic [1:0]             slot;
    logic                   ctr_load, ctr_clr, ctr_inc;
    logic [NUM_SLOTS-1:0]   wr_en_d;
    logic [NUM_SLOTS-1:0]   vld_q;
    logic                   frame_done_d, frame_done_q;
    logic                   sync_err_d, sync_err_q;
    logic [WIDTH-1:0]       ch_q [NUM_SLOTS];

    tdm_slot_ctr u_slot_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ctr_load),
        .clr_i  (ctr_clr),
        .inc_i  (ctr_inc),
        .slot_o (slot)
    );

    // Framing FSM plus channel write decode. Nothing happens without din_valid.
    always_comb begin
        state_d      = state_q;
        wr_en_d      = '0;
        ctr_load     = 1'b0;
        ctr_clr      = 1'b0;
        ctr_inc      = 1'b0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    // Words without sync are dropped silently while hunting.
                    if (frame_sync) begin
                        wr_en_d  = slot_onehot(SLOT_A);
                        ctr_load = 1'b1;
                        state_d  = ST_LOCKED;
                    end
                end

                ST_LOCKED: begin
                    if (frame_sync) begin
                        // Sync always (re)starts a frame at slot a; it is an
                        // error only if it cut the previous frame short.
                        wr_en_d    = slot_onehot(SLOT_A);
                        ctr_load   = 1'b1;
                        sync_err_d = (slot != SLOT_A);
                    end else if (slot == SLOT_A) begin
                        // Slot a without its marker: lock is lost, word dropped.
                        sync_err_d = 1'b1;
                        ctr_clr    = 1'b1;
                        state_d    = ST_HUNT;
                    end else begin
                        wr_en_d = slot_onehot(slot);
                        ctr_inc = 1'b1;
                        // Reaching d by increment implies a, b, c were written
                        // since the last sync with no error in between.
                        frame_done_d = (slot == SLOT_D);
                    end
                end

                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            vld_q        <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            vld_q        <= wr_en_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (wr_en_d[i]) begin
                    ch_q[i] <= din;
                end
            end
        end
    end

    assign a          = ch_q[0];
    assign b          = ch_q[1];
    assign c          = ch_q[2];
    assign d          = ch_q[3];
    assign a_vld      = vld_q[0];
    assign b_vld      = vld_q[1];
    assign c_vld      = vld_q[2];
    assign d_vld      = vld_q[3];
    assign s1         = slot[1];
    assign s0         = slot[0];
    assign locked     = (state_q == ST_LOCKED);
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule
